// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential binary-to-BCD converter (shift-and-add-3, one bit per
//            clock) with a start/busy/done handshake. The result and overflow
//            flag are held stable until the next conversion completes.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - conversion request, sampled only while idle
//            bin    - binary operand, captured on the accepting edge
//            busy   - high while a conversion is in progress
//            done   - one-cycle pulse marking a new result
//            bcd    - packed BCD result, digit i at bits [4i+3:4i]
//            ovf    - value did not fit in DIGITS digits; held with bcd
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;   // BCD field width
    localparam int TW = BW + W;       // whole working register width
    localparam int CW = $clog2(W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic [TW-1:0]   work;            // {BCD field, binary field}
    logic [CW-1:0]   cnt;
    logic            sticky;
    logic [BW-1:0]   corr;
    logic [TW-1:0]   full;
    logic [TW-1:0]   shifted;
    logic            out_bit;
    logic            last;

    // Per-digit add-3 correction. A digit >= 5 becomes at most 12, so the
    // 4-bit add never carries into the next digit.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] dig;
            assign dig = work[W + 4*i +: 4];
            assign corr[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
    endgenerate

    assign full    = {corr, work[W-1:0]};
    assign shifted = {full[TW-2:0], 1'b0};
    assign out_bit = full[TW-1];          // bit lost off the top digit
    assign last    = (cnt == CW'(1));
    assign busy    = (state == SHIFT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    accept    = 1'b1;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: working register, counter, sticky overflow, held outputs.
    // bcd/ovf are written only on the final shift edge so they stay
    // untouched when a new conversion is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                work   <= {{BW{1'b0}}, bin};
                cnt    <= CW'(W);
                sticky <= 1'b0;
            end else if (state == SHIFT) begin
                work   <= shifted;
                cnt    <= cnt - CW'(1);
                sticky <= sticky | out_bit;
                if (last) begin
                    bcd  <= shifted[TW-1:W];
                    ovf  <= sticky | out_bit;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
